fp_norm_seq: RTL and testbench

FP_NORM_SEQ -- requirements
Module: fp_norm_seq

---
 rtl/fp_norm_seq_pkg.sv | 21 ++
 rtl/exp_step.sv | 37 +++
 rtl/fp_norm_seq.sv | 175 +++++++++++++++++
 tb/tb_fp_norm_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fp_norm_seq_pkg                                           |
// | Purpose  : Shared widths, constants and FSM state encoding for the   |
// |            sequential floating-point normaliser.                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fp_norm_seq_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 25;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/exp_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : exp_step                                                  |
// | Purpose  : Exponent increment/decrement by one, built as a ripple of |
// |            full-adder cells. dec_i=0 adds 1, dec_i=1 subtracts 1.    |
// |            co_o is carry-out on increment, borrow-out on decrement.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module exp_step
  import fp_norm_seq_pkg::*;
(
  input  logic [EXP_W-1:0] a_i,
  input  logic             dec_i,
  output logic [EXP_W-1:0] y_o,
  output logic             co_o
);

  // Decrement is done as a + 0xFF (two's complement of 1).
  logic [EXP_W-1:0] w_b;
  logic [EXP_W:0]   w_c;

  assign w_b    = {EXP_W{dec_i}} | {{(EXP_W-1){1'b0}}, 1'b1};
  assign w_c[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < EXP_W; gi++) begin : g_bit
      assign y_o[gi]    = a_i[gi] ^ w_b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (a_i[gi] & w_b[gi]) | (w_c[gi] & (a_i[gi] ^ w_b[gi]));
    end
  endgenerate

  // A missing carry on the add-0xFF path means the subtraction borrowed.
  assign co_o = dec_i ? ~w_c[EXP_W] : w_c[EXP_W];

endmodule
`default_nettype wire

// File: rtl/fp_norm_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fp_norm_seq                                               |
// | Purpose  : Sequential post-add normaliser. Captures a raw mantissa   |
// |            sum, fixes a carry with one right shift or normalises     |
// |            with one left shift per cycle, and reports zero,          |
// |            overflow, underflow and sticky status.                    |
// | Options  : FP_NORM_STICKY_EN - keep a sticky bit of right-shifted    |
// |            out mantissa bits; otherwise sticky is tied to 0.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fp_norm_seq
  import fp_norm_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [MAN_W-1:0] man_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-3:0] man_out,
  output logic             zero,
  output logic             overflow,
  output logic             underflow,
  output logic             sticky
);

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0] man_q, man_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [EXP_W-1:0] w_step_y;
  logic             w_step_co;

  // A carry needs an increment; every other NORM step that touches the
  // exponent is a decrement.
  exp_step u_exp_step (
    .a_i   (exp_q),
    .dec_i (~man_q[MAN_W-1]),
    .y_o   (w_step_y),
    .co_o  (w_step_co)
  );

  // Next-state and datapath decisions; NORM resolves one priority step per cycle.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    man_d   = man_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sign_in;
          exp_d   = exp_in;
          man_d   = man_in;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (man_q == '0) begin
          zero_d  = 1'b1;
          exp_d   = '0;
          man_d   = '0;
          state_d = DONE;
        end else if (man_q[MAN_W-1]) begin
          // Incrementing into (or past) the all-ones exponent overflows.
          if (w_step_co || (w_step_y == EXP_MAX)) begin
            ovf_d = 1'b1;
            exp_d = EXP_MAX;
            man_d = '0;
          end else begin
            exp_d = w_step_y;
            man_d = man_q >> 1;
          end
          state_d = DONE;
        end else if (man_q[MAN_W-2]) begin
          // A zero exponent with the hidden bit set is promoted to 1.
          if (exp_q == '0) begin
            exp_d = {{(EXP_W-1){1'b0}}, 1'b1};
          end
          state_d = DONE;
        end else if (exp_q <= {{(EXP_W-1){1'b0}}, 1'b1}) begin
          unf_d   = 1'b1;
          exp_d   = '0;
          state_d = DONE;
        end else begin
          man_d = man_q << 1;
          exp_d = w_step_y;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef FP_NORM_STICKY_EN
  logic sticky_q, sticky_d;

  // Sticky collects the bit lost by the carry right shift; cleared at capture.
  always_comb begin
    sticky_d = sticky_q;
    if ((state_q == IDLE) && in_valid) begin
      sticky_d = 1'b0;
    end else if ((state_q == NORM) && (man_q != '0) && man_q[MAN_W-1]) begin
      sticky_d = sticky_q | man_q[0];
    end
  end

  // Sticky register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sign_out  = sign_q;
  assign exp_out   = exp_q;
  assign man_out   = man_q[MAN_W-3:0];
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fp_norm_seq                                            |
// | Purpose  : Directed, table-driven bench for fp_norm_seq plus hand    |
// |            sequences for back-pressure and mid-operation reset.      |
// | Options  : FP_NORM_STICKY_EN changes the expected sticky values.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_fp_norm_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [24:0] man_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] man_out;
  logic        zero;
  logic        overflow;
  logic        underflow;
  logic        sticky;

  int tests  = 0;
  int failed = 0;

`ifdef FP_NORM_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  // Vector record; xf = {zero, overflow, underflow, sticky}.
  // lat counts clock edges from the capture edge (counted as 1) up to and
  // including the edge after which out_valid is first high.
  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    logic [7:0]  xe;
    logic [22:0] xm;
    logic [3:0]  xf;
    int          lat;
  } vec_t;

  vec_t tv[11];

  always #5 clk = ~clk;

  fp_norm_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .man_in    (man_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .man_out   (man_out),
    .zero      (zero),
    .overflow  (overflow),
    .underflow (underflow),
    .sticky    (sticky)
  );

  function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [24:0] m,
                              input logic [7:0] xe, input logic [22:0] xm,
                              input logic [3:0] xf, input int lat);
    vec_t v;
    v.s = s; v.e = e; v.m = m; v.xe = xe; v.xm = xm; v.xf = xf; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, " exp_out"}, 32'(exp_out), 32'(v.xe));
    check({tag, " man_out"}, 32'(man_out), 32'(v.xm));
    check({tag, " sign"},    32'(sign_out), 32'(v.s));
    check({tag, " flags"},   32'({zero, overflow, underflow, sticky}), 32'(v.xf));
  endtask

  // Present v, keep in_valid high with junk while busy, wait for out_valid.
  task automatic start_and_wait(input vec_t v, input string tag, output logic got, output int cyc);
    @(negedge clk);
    check({tag, " in_ready before capture"}, 32'(in_ready), 32'd1);
    sign_in  = v.s;
    exp_in   = v.e;
    man_in   = v.m;
    in_valid = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1;
    sign_in = ~v.s;
    exp_in  = 8'hA5;
    man_in  = 25'h15A5A5A;
    got = 1'b0;
    while (!got && cyc < 64) begin
      @(posedge clk);
      cyc++;
      #1;
      got = out_valid;
      if (!got) check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic run(input vec_t v, input string tag);
    logic got;
    int   cyc;
    start_and_wait(v, tag, got, cyc);
    if (!got) begin
      tests++;
      failed++;
      $display("FAIL %s timeout: got no out_valid, expected within %0d edges", tag, v.lat);
    end else begin
      check({tag, " latency"}, 32'(cyc), 32'(v.lat));
      check_result(tag, v);
      @(posedge clk);
      #1;
      check({tag, " back to idle"}, 32'({in_ready, out_valid}), 32'b10);
    end
  endtask

  initial begin
    logic got;
    int   cyc;

    tv[0]  = mk(1'b0, 8'h80, 25'h0800000, 8'h80, 23'h000000, 4'b0000, 2);
    tv[1]  = mk(1'b1, 8'h80, 25'h1000001, 8'h81, 23'h000000, {3'b000, STK}, 2);
    tv[2]  = mk(1'b0, 8'h80, 25'h0000001, 8'h69, 23'h000000, 4'b0000, 25);
    tv[3]  = mk(1'b0, 8'h03, 25'h0000100, 8'h00, 23'h000400, 4'b0010, 4);
    tv[4]  = mk(1'b0, 8'hFE, 25'h1800000, 8'hFF, 23'h000000, 4'b0100, 2);
    tv[5]  = mk(1'b1, 8'h55, 25'h0000000, 8'h00, 23'h000000, 4'b1000, 2);
    tv[6]  = mk(1'b0, 8'h00, 25'h0C00000, 8'h01, 23'h400000, 4'b0000, 2);
    tv[7]  = mk(1'b0, 8'h10, 25'h0123456, 8'h0D, 23'h11A2B0, 4'b0000, 5);
    tv[8]  = mk(1'b0, 8'h7F, 25'h1FFFFFF, 8'h80, 23'h7FFFFF, {3'b000, STK}, 2);
    tv[9]  = mk(1'b0, 8'h02, 25'h0400000, 8'h01, 23'h000000, 4'b0000, 3);
    tv[10] = mk(1'b1, 8'h01, 25'h0400000, 8'h00, 23'h400000, 4'b0010, 2);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sign_in   = 1'b0;
    exp_in    = '0;
    man_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset handshake", 32'({in_ready, out_valid}), 32'b10);
    check("reset data", 32'({sign_out, exp_out, man_out}), 32'd0);
    check("reset flags", 32'({zero, overflow, underflow, sticky}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run(tv[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: result must hold for 5 cycles with out_ready low.
    out_ready = 1'b0;
    start_and_wait(tv[3], "bp", got, cyc);
    if (!got) begin
      tests++;
      failed++;
      $display("FAIL bp timeout: got no out_valid, expected within 4 edges");
    end else begin
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        check("bp hold handshake", 32'({in_ready, out_valid}), 32'b01);
        check_result("bp hold", tv[3]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp release idle", 32'({in_ready, out_valid}), 32'b10);
    end

    // Reset in the middle of a long left-shift run.
    @(negedge clk);
    sign_in  = 1'b1;
    exp_in   = 8'h80;
    man_in   = 25'h0000001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid-shift busy", 32'({in_ready, out_valid}), 32'b00);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid reset handshake", 32'({in_ready, out_valid}), 32'b10);
    check("mid reset data", 32'({sign_out, exp_out, man_out}), 32'd0);
    check("mid reset flags", 32'({zero, overflow, underflow, sticky}), 32'd0);
    rst_n = 1'b1;
    run(tv[7], "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
